// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with forwarding, load-use stall and flush
// Inputs : clk, rst_n (sync, active-low), decoded instruction fields (in_*) under in_valid/in_ready,
//          ex_result, MEM and WB writeback candidates, flush, out_ready
// Outputs: in_ready, out_valid, operand_a/b, store_data, alu_op, out_rd, out_wen, out_is_load, out_pc
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_alu_op,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [31:0] ex_result,
  input  logic        mem_valid,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_valid,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] store_data,
  output logic [4:0]  alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_is_load,
  output logic [31:0] out_pc
);
  logic        hazard;
  logic        cap;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  // Youngest producer wins; a held load has no result yet, so it never forwards from EX
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    fwd = (rs == 5'd0) ? rf :
          (out_valid & out_wen & ~out_is_load & (out_rd == rs)) ? ex_result :
          (mem_valid & mem_wen & (mem_rd == rs)) ? mem_data :
          (wb_valid & wb_wen & (wb_rd == rs)) ? wb_data : rf;
  endfunction
  always_comb begin
    hazard = out_valid & out_is_load & out_wen & (out_rd != 5'd0) &
             ((out_rd == in_rs1) | ((out_rd == in_rs2) & ~in_use_imm));
    in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    cap = in_valid & in_ready;
    fwd_rs1 = fwd(in_rs1, in_rs1_data);
    fwd_rs2 = fwd(in_rs2, in_rs2_data);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      operand_a   <= '0;
      operand_b   <= '0;
      store_data  <= '0;
      alu_op      <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_is_load <= 1'b0;
      out_pc      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (cap) begin
      out_valid   <= 1'b1;
      operand_a   <= fwd_rs1;
      operand_b   <= in_use_imm ? in_imm : fwd_rs2;
      store_data  <= fwd_rs2;
      alu_op      <= in_alu_op;
      out_rd      <= in_rd;
      out_wen     <= in_wen;
      out_is_load <= in_is_load;
      out_pc      <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
